// File: rtl/axis_width_pkg.sv
// rtl/axis_width_pkg.sv - shared types and elaboration helpers for the width-converting stream slice
package axis_width_pkg;

    typedef enum logic [1:0] {
        PASS     = 2'd0,
        UPSIZE   = 2'd1,
        DOWNSIZE = 2'd2
    } mode_e;

    // Width ratio between the wider and the narrower side (1 when equal)
    function automatic int ratio(input int a, input int b);
        int lo;
        int hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (lo < 1) begin
            return 1;
        end
        return hi / lo;
    endfunction

    // Slot counter width; never narrower than one bit so pass mode still elaborates
    function automatic int cnt_width(input int r);
        return (r <= 2) ? 1 : $clog2(r);
    endfunction

    function automatic mode_e sel_mode(input int in_bytes, input int out_bytes);
        if (in_bytes == out_bytes) begin
            return PASS;
        end
        return (out_bytes > in_bytes) ? UPSIZE : DOWNSIZE;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry registered output stage carrying data and last
module axis_skid_buffer #(
    parameter int BYTES = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [BYTES*8-1:0] i_s_data,
    input  logic               i_s_last,
    input  logic               i_s_valid,
    output logic               o_s_ready,
    output logic [BYTES*8-1:0] o_m_data,
    output logic               o_m_last,
    output logic               o_m_valid,
    input  logic               i_m_ready
);

    logic [BYTES*8-1:0] r_m_data;
    logic               r_m_last;
    logic               r_m_valid;
    logic [BYTES*8-1:0] r_sk_data;
    logic               r_sk_last;
    logic               r_sk_valid;
    logic               r_s_ready;
    logic               w_push;

    // Ready is a flop that tracks "skid empty", so m_ready never reaches s_ready
    assign w_push    = i_s_valid & r_s_ready;
    assign o_s_ready = r_s_ready;
    assign o_m_data  = r_m_data;
    assign o_m_last  = r_m_last;
    assign o_m_valid = r_m_valid;

    // Main register refills from skid first, then from input; skid only catches a beat while main stalls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_m_data   <= '0;
            r_m_last   <= 1'b0;
            r_m_valid  <= 1'b0;
            r_sk_data  <= '0;
            r_sk_last  <= 1'b0;
            r_sk_valid <= 1'b0;
            r_s_ready  <= 1'b0;
        end else if (!r_m_valid || i_m_ready) begin
            r_s_ready <= 1'b1;
            if (r_sk_valid) begin
                r_m_data   <= r_sk_data;
                r_m_last   <= r_sk_last;
                r_m_valid  <= 1'b1;
                r_sk_valid <= 1'b0;
            end else begin
                r_m_valid <= w_push;
                if (w_push) begin
                    r_m_data <= i_s_data;
                    r_m_last <= i_s_last;
                end
            end
        end else if (w_push) begin
            r_sk_data  <= i_s_data;
            r_sk_last  <= i_s_last;
            r_sk_valid <= 1'b1;
            r_s_ready  <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_width_pipe_reg.sv
// rtl/axis_width_pipe_reg.sv - registered stream slice with integer-ratio width conversion
module axis_width_pipe_reg
    import axis_width_pkg::*;
#(
    parameter int INPUT_BYTES  = 1,
    parameter int OUTPUT_BYTES = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [INPUT_BYTES*8-1:0]  axis_s_data_i,
    input  logic                      axis_s_valid_i,
    output logic                      axis_s_ready_o,
    input  logic                      axis_s_last_i,
    output logic [OUTPUT_BYTES*8-1:0] axis_m_data_o,
    output logic                      axis_m_valid_o,
    input  logic                      axis_m_ready_i,
    output logic                      axis_m_last_o
);

    localparam int    R    = ratio(INPUT_BYTES, OUTPUT_BYTES);
    localparam int    MAXB = (INPUT_BYTES > OUTPUT_BYTES) ? INPUT_BYTES : OUTPUT_BYTES;
    localparam int    MINB = (INPUT_BYTES > OUTPUT_BYTES) ? OUTPUT_BYTES : INPUT_BYTES;
    localparam mode_e MODE = sel_mode(INPUT_BYTES, OUTPUT_BYTES);

    if ((MINB < 1) || (R * MINB != MAXB)) begin : g_bad_ratio
        $error("axis_width_pipe_reg: widths must be >=1 and integer multiples");
    end

    logic [OUTPUT_BYTES*8-1:0] w_k_data;
    logic                      w_k_last;
    logic                      w_k_valid;
    logic                      w_k_ready;

    if (MODE == PASS) begin : g_pass
        assign w_k_data       = axis_s_data_i;
        assign w_k_last       = axis_s_last_i;
        assign w_k_valid      = axis_s_valid_i;
        assign axis_s_ready_o = w_k_ready;
    end else if (MODE == UPSIZE) begin : g_up
        localparam int             CW        = cnt_width(R);
        localparam logic [CW-1:0]  LAST_SLOT = CW'(R - 1);

        logic [OUTPUT_BYTES*8-1:0] r_acc;
        logic [OUTPUT_BYTES*8-1:0] w_word;
        logic [CW-1:0]             r_cnt;
        logic                      w_accept;
        logic                      w_done;

        // A word completes on the last slot or early on a last beat; the completing beat goes straight to the skid
        assign w_accept       = axis_s_valid_i & w_k_ready;
        assign w_done         = (r_cnt == LAST_SLOT) | axis_s_last_i;
        assign w_k_valid      = axis_s_valid_i & w_done;
        assign w_k_data       = w_word;
        assign w_k_last       = axis_s_last_i;
        assign axis_s_ready_o = w_k_ready;

        // Merge the incoming beat into its little-endian slot; unfilled slots stay zero
        always_comb begin
            w_word = r_acc;
            w_word[r_cnt*INPUT_BYTES*8 +: INPUT_BYTES*8] = axis_s_data_i;
        end

        // Accumulator clears after every emitted word so early words carry zero padding
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_done) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_word;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end else begin : g_down
        localparam int             CW        = cnt_width(R);
        localparam logic [CW-1:0]  LAST_SLOT = CW'(R - 1);

        logic [INPUT_BYTES*8-1:0] r_word;
        logic                     r_wlast;
        logic                     r_wvalid;
        logic [CW-1:0]            r_idx;
        logic                     w_s_ready;
        logic                     w_accept;

        // Slice 0 bypasses the holder so it is visible one cycle after acceptance;
        // the holder keeps the remaining slices and blocks the next word until it drains
        assign w_s_ready      = w_k_ready & ~r_wvalid;
        assign w_accept       = axis_s_valid_i & w_s_ready;
        assign axis_s_ready_o = w_s_ready;
        assign w_k_valid      = r_wvalid | w_accept;
        assign w_k_data       = r_wvalid ? r_word[r_idx*OUTPUT_BYTES*8 +: OUTPUT_BYTES*8]
                                         : axis_s_data_i[OUTPUT_BYTES*8-1:0];
        assign w_k_last       = r_wvalid & r_wlast & (r_idx == LAST_SLOT);

        // Step through remaining slices each time the skid takes one
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_word   <= '0;
                r_wlast  <= 1'b0;
                r_wvalid <= 1'b0;
                r_idx    <= '0;
            end else if (r_wvalid) begin
                if (w_k_ready) begin
                    if (r_idx == LAST_SLOT) begin
                        r_wvalid <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
            end else if (w_accept) begin
                r_word   <= axis_s_data_i;
                r_wlast  <= axis_s_last_i;
                r_wvalid <= 1'b1;
                r_idx    <= CW'(1);
            end
        end
    end

    axis_skid_buffer #(
        .BYTES(OUTPUT_BYTES)
    ) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_s_data  (w_k_data),
        .i_s_last  (w_k_last),
        .i_s_valid (w_k_valid),
        .o_s_ready (w_k_ready),
        .o_m_data  (axis_m_data_o),
        .o_m_last  (axis_m_last_o),
        .o_m_valid (axis_m_valid_o),
        .i_m_ready (axis_m_ready_i)
    );

endmodule

// File: tb/tb_axis_width_pipe_reg.sv
// tb/tb_axis_width_pipe_reg.sv - directed checks of pass, upsize, downsize, backpressure and reset
module tb_axis_width_pipe_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // a: 1B->1B, b: 1B->4B, c: 4B->1B, d: 2B->4B
    logic [7:0]  a_sd, a_md;
    logic        a_sv, a_sl, a_sr, a_mv, a_ml, a_mr;
    logic [7:0]  b_sd;
    logic [31:0] b_md;
    logic        b_sv, b_sl, b_sr, b_mv, b_ml, b_mr;
    logic [31:0] c_sd;
    logic [7:0]  c_md;
    logic        c_sv, c_sl, c_sr, c_mv, c_ml, c_mr;
    logic [15:0] d_sd;
    logic [31:0] d_md;
    logic        d_sv, d_sl, d_sr, d_mv, d_ml, d_mr;

    axis_width_pipe_reg #(.INPUT_BYTES(1), .OUTPUT_BYTES(1)) u_a (
        .clk_i(clk), .rst_i(rst), .axis_s_data_i(a_sd), .axis_s_valid_i(a_sv),
        .axis_s_ready_o(a_sr), .axis_s_last_i(a_sl), .axis_m_data_o(a_md),
        .axis_m_valid_o(a_mv), .axis_m_ready_i(a_mr), .axis_m_last_o(a_ml));
    axis_width_pipe_reg #(.INPUT_BYTES(1), .OUTPUT_BYTES(4)) u_b (
        .clk_i(clk), .rst_i(rst), .axis_s_data_i(b_sd), .axis_s_valid_i(b_sv),
        .axis_s_ready_o(b_sr), .axis_s_last_i(b_sl), .axis_m_data_o(b_md),
        .axis_m_valid_o(b_mv), .axis_m_ready_i(b_mr), .axis_m_last_o(b_ml));
    axis_width_pipe_reg #(.INPUT_BYTES(4), .OUTPUT_BYTES(1)) u_c (
        .clk_i(clk), .rst_i(rst), .axis_s_data_i(c_sd), .axis_s_valid_i(c_sv),
        .axis_s_ready_o(c_sr), .axis_s_last_i(c_sl), .axis_m_data_o(c_md),
        .axis_m_valid_o(c_mv), .axis_m_ready_i(c_mr), .axis_m_last_o(c_ml));
    axis_width_pipe_reg #(.INPUT_BYTES(2), .OUTPUT_BYTES(4)) u_d (
        .clk_i(clk), .rst_i(rst), .axis_s_data_i(d_sd), .axis_s_valid_i(d_sv),
        .axis_s_ready_o(d_sr), .axis_s_last_i(d_sl), .axis_m_data_o(d_md),
        .axis_m_valid_o(d_mv), .axis_m_ready_i(d_mr), .axis_m_last_o(d_ml));

    logic [7:0] up_in  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] dn_exp [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

    int          src;
    int          nexp;
    logic        acc;
    logic        p_stall;
    logic [31:0] p_md;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bval(input int n);
        int v;
        v = n * 7 + 3;
        return v[7:0];
    endfunction

    function automatic logic [31:0] exp_word(input int w);
        return {bval(4*w+3), bval(4*w+2), bval(4*w+1), bval(4*w)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        a_sd = '0; a_sv = 0; a_sl = 0; a_mr = 1;
        b_sd = '0; b_sv = 0; b_sl = 0; b_mr = 1;
        c_sd = '0; c_sv = 0; c_sl = 0; c_mr = 1;
        d_sd = '0; d_sv = 0; d_sl = 0; d_mr = 1;
        p_stall = 0; p_md = '0; acc = 0;

        // reset state
        repeat (2) tick();
        chk("rst_a_sready", a_sr, 0);
        chk("rst_a_mvalid", a_mv, 0);
        chk("rst_a_mdata", a_md, 0);
        chk("rst_b_mvalid", b_mv, 0);
        chk("rst_b_mdata", b_md, 0);
        chk("rst_c_sready", c_sr, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_a_sready", a_sr, 1);
        chk("post_rst_b_sready", b_sr, 1);
        chk("post_rst_c_sready", c_sr, 1);
        chk("post_rst_d_sready", d_sr, 1);

        // equal widths, sink always ready
        for (int i = 0; i < 16; i++) begin
            a_sv = 1; a_sd = i[7:0]; a_sl = (i == 15);
            tick();
            chk("pass_valid", a_mv, 1);
            chk("pass_data", a_md, i);
            chk("pass_last", a_ml, (i == 15));
        end
        a_sv = 0; a_sl = 0;
        tick();
        chk("pass_idle", a_mv, 0);

        // backpressure, 1B->1B
        src = 0; nexp = 0;
        for (int cyc = 0; cyc < 60 && nexp < 8; cyc++) begin
            a_mr = (cyc >= 10);
            a_sv = (src < 8); a_sd = 8'h20 + src[7:0]; a_sl = (src == 7);
            if (cyc >= 1 && cyc < 10) begin
                chk("bp_hold_valid", a_mv, 1);
                chk("bp_hold_data", a_md, 8'h20);
            end
            if (cyc >= 2 && cyc < 10) chk("bp_sready_low", a_sr, 0);
            if (cyc == 9) chk("bp_buffered", src, 2);
            if (a_mv && a_mr) begin
                chk("bp_data", a_md, 8'h20 + nexp);
                chk("bp_last", a_ml, (nexp == 7));
                nexp++;
            end
            acc = a_sv && a_sr;
            tick();
            if (acc) src++;
        end
        chk("bp_count", nexp, 8);
        a_sv = 0; a_sl = 0; a_mr = 1;
        tick();

        // upsize 1B->4B with early last
        for (int i = 0; i < 6; i++) begin
            b_sv = 1; b_sd = up_in[i]; b_sl = (i == 5);
            tick();
            if (i < 3) chk("up_fill_invalid", b_mv, 0);
            if (i == 3) begin
                chk("up_w0_valid", b_mv, 1);
                chk("up_w0_data", b_md, 32'h44332211);
                chk("up_w0_last", b_ml, 0);
            end
            if (i == 4) chk("up_gap", b_mv, 0);
            if (i == 5) begin
                chk("up_w1_valid", b_mv, 1);
                chk("up_w1_data", b_md, 32'h00006655);
                chk("up_w1_last", b_ml, 1);
            end
        end
        b_sv = 0; b_sl = 0;
        tick();
        chk("up_idle", b_mv, 0);

        // downsize 4B->1B with a second word pending
        c_sv = 1; c_sd = 32'hDDCCBBAA; c_sl = 1;
        tick();
        c_sd = 32'h44332211; c_sl = 0;
        for (int k = 0; k < 8; k++) begin
            chk("dn_valid", c_mv, 1);
            chk("dn_data", c_md, dn_exp[k]);
            chk("dn_last", c_ml, (k == 3));
            if (k < 4) chk("dn_sready", c_sr, (k == 3));
            tick();
            if (k == 3) c_sv = 0;
        end
        chk("dn_idle", c_mv, 0);

        // random valid/ready, 2B->4B, 1000-byte packet
        src = 0; nexp = 0; p_stall = 0;
        for (int cyc = 0; cyc < 20000 && nexp < 250; cyc++) begin
            if (!d_sv && src < 500) d_sv = ($urandom_range(0, 1) == 1);
            d_sd = {bval(2*src+1), bval(2*src)};
            d_sl = (src == 499);
            d_mr = ($urandom_range(0, 1) == 1);
            if (p_stall) begin
                chk("rnd_hold_valid", d_mv, 1);
                chk("rnd_hold_data", d_md, p_md);
            end
            if (d_mv && d_mr) begin
                chk("rnd_data", d_md, exp_word(nexp));
                chk("rnd_last", d_ml, (nexp == 249));
                nexp++;
            end
            p_stall = d_mv && !d_mr;
            p_md = d_md;
            acc = d_sv && d_sr;
            tick();
            if (acc) begin
                src++;
                d_sv = 0;
            end
        end
        chk("rnd_count", nexp, 250);
        d_sv = 0; d_sl = 0; d_mr = 1;
        tick();

        // reset in the middle of an upsize packet
        b_mr = 0;
        for (int i = 0; i < 5; i++) begin
            b_sv = 1; b_sd = 8'hA1 + i[7:0]; b_sl = 0;
            tick();
        end
        chk("mid_pre_valid", b_mv, 1);
        chk("mid_pre_data", b_md, 32'hA4A3A2A1);
        b_sv = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", b_mv, 0);
        chk("mid_rst_data", b_md, 0);
        chk("mid_rst_last", b_ml, 0);
        chk("mid_rst_sready", b_sr, 0);
        tick();
        rst = 1'b0; b_mr = 1;
        tick();
        chk("mid_post_sready", b_sr, 1);
        for (int i = 0; i < 4; i++) begin
            b_sv = 1; b_sd = 8'h01 + i[7:0]; b_sl = 0;
            tick();
        end
        chk("mid_fresh_valid", b_mv, 1);
        chk("mid_fresh_data", b_md, 32'h04030201);
        chk("mid_fresh_last", b_ml, 0);
        b_sv = 0;
        tick();
        chk("mid_idle", b_mv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
